// File: rtl/mod_count_checker_pkg.sv
// Shared definitions for the modulo-counter checker: FSM encoding, error codes,
// statistic width and the error-code helper.
package mod_count_checker_pkg;

  localparam int STAT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CHECK = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_COUNT = 2'b01;
  localparam logic [1:0] ERR_CARRY = 2'b10;
  localparam logic [1:0] ERR_BOTH  = 2'b11;

  function automatic logic [1:0] err_code_of(input logic count_mis, input logic carry_mis);
    logic [1:0] code;
    case ({carry_mis, count_mis})
      2'b01:   code = ERR_COUNT;
      2'b10:   code = ERR_CARRY;
      2'b11:   code = ERR_BOTH;
      default: code = ERR_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/mod_count_checker_if.sv
// Observation/result bundle of the modulo-counter checker.
// CHECKER_ERR_CAPTURE_EN adds the first-mismatch capture signals err_exp/err_obs.
interface mod_count_checker_if #(
  parameter int W = 4
);
  import mod_count_checker_pkg::*;

  logic              clear;
  logic              chk_en;
  logic              en_obs;
  logic [W-1:0]      count_obs;
  logic              carry_obs;
  logic              err_flag;
  logic [1:0]        err_code;
  logic [STAT_W-1:0] err_cnt;
  logic [STAT_W-1:0] wrap_cnt;
  logic [1:0]        state_o;

`ifdef CHECKER_ERR_CAPTURE_EN
  logic [W-1:0]      err_exp;
  logic [W-1:0]      err_obs;

  modport master (
    output clear, chk_en, en_obs, count_obs, carry_obs,
    input  err_flag, err_code, err_cnt, wrap_cnt, state_o, err_exp, err_obs
  );

  modport slave (
    input  clear, chk_en, en_obs, count_obs, carry_obs,
    output err_flag, err_code, err_cnt, wrap_cnt, state_o, err_exp, err_obs
  );
`else
  modport master (
    output clear, chk_en, en_obs, count_obs, carry_obs,
    input  err_flag, err_code, err_cnt, wrap_cnt, state_o
  );

  modport slave (
    input  clear, chk_en, en_obs, count_obs, carry_obs,
    output err_flag, err_code, err_cnt, wrap_cnt, state_o
  );
`endif

endinterface

// File: rtl/mod_count_checker_sat_counter8.sv
// 8-bit event counter with synchronous clear; sat=1 saturates at all-ones,
// sat=0 wraps modulo 256.
module sat_counter8
  import mod_count_checker_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              inc,
  input  logic              sat,
  output logic [STAT_W-1:0] count
);

  localparam logic [STAT_W-1:0] CNT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] CNT_ONE = STAT_W'(1);

  logic [STAT_W-1:0] count_r;
  logic [STAT_W-1:0] count_s;

  // Next count: clear wins over increment
  always_comb begin
    count_s = count_r;
    if (clear) begin
      count_s = {STAT_W{1'b0}};
    end else if (inc) begin
      if (sat && (count_r == CNT_MAX)) begin
        count_s = count_r;
      end else begin
        count_s = count_r + CNT_ONE;
      end
    end else begin
      count_s = count_r;
    end
  end

  // Count register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {STAT_W{1'b0}};
    end else begin
      count_r <= count_s;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/mod_count_checker.sv
// Checker for a 0..MOD_MAX modulo counter: shadow model, sticky error state and
// statistics. Optional macro CHECKER_ERR_CAPTURE_EN adds first-mismatch capture.
module mod_count_checker
  import mod_count_checker_pkg::*;
#(
  parameter int MOD_MAX     = 12,
  parameter int W           = 4,
  parameter int STOP_ON_ERR = 0
) (
  input logic                clk,
  input logic                reset,
  mod_count_checker_if.slave bus
);

  localparam logic [W-1:0] MAX_W = W'(MOD_MAX);
  localparam logic [W-1:0] ONE_W = W'(1);

  function automatic logic [W-1:0] next_val(input logic [W-1:0] v);
    logic [W-1:0] r;
    if (v >= MAX_W) begin
      r = {W{1'b0}};
    end else begin
      r = v + ONE_W;
    end
    return r;
  endfunction

  state_t            state_r;
  state_t            state_s;
  logic [W-1:0]      exp_cnt_r;
  logic [W-1:0]      exp_cnt_s;
  logic              exp_carry_r;
  logic              exp_carry_s;
  logic [W-1:0]      base_s;
  logic              count_mis_s;
  logic              carry_mis_s;
  logic              mismatch_s;
  logic              err_hit_s;
  logic              wrap_hit_s;
  logic              err_flag_r;
  logic              err_flag_s;
  logic [1:0]        err_code_r;
  logic [1:0]        err_code_s;
  logic [STAT_W-1:0] err_cnt_s;
  logic [STAT_W-1:0] wrap_cnt_s;

  // Comparison against the model, plus the statistic increment strobes
  always_comb begin
    count_mis_s = 1'b0;
    carry_mis_s = 1'b0;
    if (state_r == ST_CHECK) begin
      count_mis_s = (bus.count_obs != exp_cnt_r);
      carry_mis_s = (bus.carry_obs != exp_carry_r);
    end else begin
      count_mis_s = 1'b0;
      carry_mis_s = 1'b0;
    end
    mismatch_s = count_mis_s | carry_mis_s;
    err_hit_s  = mismatch_s & ~bus.clear;
    wrap_hit_s = bus.en_obs && (bus.count_obs == MAX_W) &&
                 ((state_r == ST_IDLE) || (state_r == ST_CHECK));
  end

  // FSM next state; clear overrides everything
  always_comb begin
    state_s = state_r;
    if (bus.clear) begin
      state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.chk_en) state_s = ST_CHECK;
          else            state_s = ST_IDLE;
        end
        ST_CHECK: begin
          if (mismatch_s && (STOP_ON_ERR != 0)) state_s = ST_HALT;
          else if (!bus.chk_en)                 state_s = ST_IDLE;
          else                                  state_s = ST_CHECK;
        end
        ST_HALT: state_s = ST_HALT;
        default: state_s = ST_IDLE;
      endcase
    end
  end

  // Shadow model; resyncs to the observed value in IDLE and on a mismatch
  // so a single glitch does not cascade into a stream of errors
  always_comb begin
    exp_cnt_s   = exp_cnt_r;
    exp_carry_s = exp_carry_r;
    base_s      = exp_cnt_r;
    if ((state_r == ST_IDLE) || mismatch_s) begin
      base_s = bus.count_obs;
    end else begin
      base_s = exp_cnt_r;
    end
    if (state_r == ST_HALT) begin
      exp_cnt_s   = exp_cnt_r;
      exp_carry_s = exp_carry_r;
    end else if (bus.en_obs) begin
      exp_cnt_s   = next_val(base_s);
      exp_carry_s = (base_s >= MAX_W);
    end else begin
      exp_cnt_s   = base_s;
      exp_carry_s = exp_carry_r;
    end
  end

  // Sticky flag and first-error code
  always_comb begin
    err_flag_s = err_flag_r;
    err_code_s = err_code_r;
    if (bus.clear) begin
      err_flag_s = 1'b0;
      err_code_s = ERR_NONE;
    end else if (err_hit_s) begin
      err_flag_s = 1'b1;
      if (!err_flag_r) begin
        err_code_s = err_code_of(count_mis_s, carry_mis_s);
      end else begin
        err_code_s = err_code_r;
      end
    end else begin
      err_flag_s = err_flag_r;
      err_code_s = err_code_r;
    end
  end

  // State, model and error registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      exp_cnt_r   <= {W{1'b0}};
      exp_carry_r <= 1'b0;
      err_flag_r  <= 1'b0;
      err_code_r  <= ERR_NONE;
    end else begin
      state_r     <= state_s;
      exp_cnt_r   <= exp_cnt_s;
      exp_carry_r <= exp_carry_s;
      err_flag_r  <= err_flag_s;
      err_code_r  <= err_code_s;
    end
  end

  sat_counter8 u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .inc   (err_hit_s),
    .sat   (1'b1),
    .count (err_cnt_s)
  );

  sat_counter8 u_wrap_cnt (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .inc   (wrap_hit_s),
    .sat   (1'b0),
    .count (wrap_cnt_s)
  );

  assign bus.err_flag = err_flag_r;
  assign bus.err_code = err_code_r;
  assign bus.err_cnt  = err_cnt_s;
  assign bus.wrap_cnt = wrap_cnt_s;
  assign bus.state_o  = state_r;

`ifdef CHECKER_ERR_CAPTURE_EN
  logic [W-1:0] err_exp_r;
  logic [W-1:0] err_exp_s;
  logic [W-1:0] err_obs_r;
  logic [W-1:0] err_obs_s;

  // Capture expected/observed values of the first mismatch only
  always_comb begin
    err_exp_s = err_exp_r;
    err_obs_s = err_obs_r;
    if (bus.clear) begin
      err_exp_s = {W{1'b0}};
      err_obs_s = {W{1'b0}};
    end else if (err_hit_s && !err_flag_r) begin
      err_exp_s = exp_cnt_r;
      err_obs_s = bus.count_obs;
    end else begin
      err_exp_s = err_exp_r;
      err_obs_s = err_obs_r;
    end
  end

  // Capture registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_exp_r <= {W{1'b0}};
      err_obs_r <= {W{1'b0}};
    end else begin
      err_exp_r <= err_exp_s;
      err_obs_r <= err_obs_s;
    end
  end

  assign bus.err_exp = err_exp_r;
  assign bus.err_obs = err_obs_r;
`endif

endmodule

// File: tb/tb_mod_count_checker.sv
// Directed bench for mod_count_checker (MOD_MAX=12, W=4): one instance with
// STOP_ON_ERR=0 and one with STOP_ON_ERR=1, driven with identical stimulus.
module tb_mod_count_checker;
  import mod_count_checker_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mod_count_checker_if #(.W(W)) bus0 ();
  mod_count_checker_if #(.W(W)) bus1 ();

  mod_count_checker #(.MOD_MAX(12), .W(W), .STOP_ON_ERR(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  mod_count_checker #(.MOD_MAX(12), .W(W), .STOP_ON_ERR(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  typedef struct {
    logic       clr;
    logic       chk;
    logic       en;
    logic [3:0] cnt;
    logic       car;
    int         flag;
    int         code;
    int         ecnt;
    int         wcnt;
    int         st;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, want);
    end
  endtask

  task automatic drive(input logic clr, input logic chk, input logic en,
                       input logic [3:0] cnt, input logic car);
    bus0.clear = clr; bus0.chk_en = chk; bus0.en_obs = en;
    bus0.count_obs = cnt; bus0.carry_obs = car;
    bus1.clear = clr; bus1.chk_en = chk; bus1.en_obs = en;
    bus1.count_obs = cnt; bus1.carry_obs = car;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input int which, input string tag, input int flag,
                           input int code, input int ecnt, input int wcnt, input int st);
    if (which == 0) begin
      check({tag, " d0 err_flag"}, int'(bus0.err_flag), flag);
      check({tag, " d0 err_code"}, int'(bus0.err_code), code);
      check({tag, " d0 err_cnt"},  int'(bus0.err_cnt),  ecnt);
      check({tag, " d0 wrap_cnt"}, int'(bus0.wrap_cnt), wcnt);
      check({tag, " d0 state_o"},  int'(bus0.state_o),  st);
    end else begin
      check({tag, " d1 err_flag"}, int'(bus1.err_flag), flag);
      check({tag, " d1 err_code"}, int'(bus1.err_code), code);
      check({tag, " d1 err_cnt"},  int'(bus1.err_cnt),  ecnt);
      check({tag, " d1 wrap_cnt"}, int'(bus1.wrap_cnt), wcnt);
      check({tag, " d1 state_o"},  int'(bus1.state_o),  st);
    end
  endtask

  task automatic add(input logic clr, input logic chk, input logic en, input int cnt,
                     input logic car, input int flag, input int code, input int ecnt,
                     input int wcnt, input int st);
    vec_t v;
    v.clr = clr; v.chk = chk; v.en = en; v.cnt = 4'(cnt); v.car = car;
    v.flag = flag; v.code = code; v.ecnt = ecnt; v.wcnt = wcnt; v.st = st;
    vq.push_back(v);
  endtask

  initial begin
    int gc;
    logic gcar;

    //   clr  chk  en   cnt car    flag code ecnt wcnt st
    add(1'b0,1'b1,1'b1,  5,1'b0,   0,   0,   0,   0,  1);  // r0 IDLE->CHECK
    add(1'b0,1'b1,1'b1,  6,1'b0,   0,   0,   0,   0,  1);
    add(1'b0,1'b1,1'b1,  5,1'b0,   1,   1,   1,   0,  1);  // r2 forced 5, model 7
    add(1'b0,1'b1,1'b1,  6,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1,  7,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1,  8,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1,  9,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1, 10,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1, 11,1'b0,   1,   1,   1,   0,  1);
    add(1'b0,1'b1,1'b1, 12,1'b0,   1,   1,   1,   1,  1);  // r9 wrap
    add(1'b0,1'b1,1'b1,  0,1'b1,   1,   1,   1,   1,  1);
    add(1'b1,1'b1,1'b1,  1,1'b0,   0,   0,   0,   0,  0);  // r11 clear
    add(1'b0,1'b1,1'b1,  2,1'b0,   0,   0,   0,   0,  1);
    add(1'b0,1'b1,1'b1,  3,1'b1,   1,   2,   1,   0,  1);  // r13 carry error
    add(1'b0,1'b1,1'b1,  4,1'b0,   1,   2,   1,   0,  1);
    add(1'b0,1'b1,1'b1,  9,1'b1,   1,   2,   2,   0,  1);  // r15 both, code stays
    add(1'b0,1'b1,1'b1, 10,1'b0,   1,   2,   2,   0,  1);
    add(1'b0,1'b1,1'b0, 11,1'b0,   1,   2,   2,   0,  1);  // r17 en_obs low
    add(1'b0,1'b1,1'b1, 11,1'b0,   1,   2,   2,   0,  1);
    add(1'b0,1'b0,1'b1, 12,1'b0,   1,   2,   2,   1,  0);  // r19 back to IDLE
    add(1'b0,1'b0,1'b1,  0,1'b1,   1,   2,   2,   1,  0);
    add(1'b1,1'b0,1'b0,  1,1'b0,   0,   0,   0,   0,  0);  // r21 clear
    add(1'b0,1'b1,1'b1,  1,1'b0,   0,   0,   0,   0,  1);
    add(1'b0,1'b1,1'b1, 15,1'b0,   1,   1,   1,   0,  1);  // r23 out of range
    add(1'b0,1'b1,1'b1,  0,1'b1,   1,   1,   1,   0,  1);  // model resynced to 0
    add(1'b0,1'b1,1'b1,  1,1'b0,   1,   1,   1,   0,  1);

    // Reset state, checked while reset is still asserted
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    #12;
    check_out(0, "reset", 0, 0, 0, 0, 0);
    tick();
    reset = 1'b0;

    // Fault-free 0..12 counter for 30 cycles
    gc = 0;
    gcar = 1'b0;
    for (int i = 0; i < 30; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'(gc), gcar);
      tick();
      gcar = (gc == 12);
      gc = (gc == 12) ? 0 : gc + 1;
    end
    check_out(0, "golden30", 0, 0, 0, 2, 1);
    check_out(1, "golden30", 0, 0, 0, 2, 1);

    // Vector table starts from a fresh reset
    reset = 1'b1;
    #1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].clr, vq[i].chk, vq[i].en, vq[i].cnt, vq[i].car);
      tick();
      check_out(0, $sformatf("r%0d", i), vq[i].flag, vq[i].code, vq[i].ecnt,
                vq[i].wcnt, vq[i].st);
`ifdef CHECKER_ERR_CAPTURE_EN
      if (i == 23) begin
        check("r23 err_obs", int'(bus0.err_obs), 15);
        check("r23 err_exp", int'(bus0.err_exp), 2);
      end
`endif
    end

    // STOP_ON_ERR: halt on the first mismatch, freeze, release with clear
    drive(1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
    tick();
    check_out(1, "stop clr", 0, 0, 0, 0, 0);
    drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0);
    tick();
    check("stop arm d1 state_o", int'(bus1.state_o), 1);
    drive(1'b0, 1'b1, 1'b1, 4'd7, 1'b0);
    tick();
    check_out(1, "stop hit", 1, 1, 1, 0, 2);
    drive(1'b0, 1'b1, 1'b1, 4'd12, 1'b0);
    repeat (3) tick();
    check_out(1, "halted", 1, 1, 1, 0, 2);
    check_out(0, "nostop", 1, 1, 4, 3, 1);
    drive(1'b1, 1'b1, 1'b1, 4'd12, 1'b0);
    tick();
    check_out(1, "halt clr", 0, 0, 0, 0, 0);
    check_out(0, "clr prec", 0, 0, 0, 0, 0);

    // 1 IDLE cycle + 300 mismatching cycles, each also a wrap event
    drive(1'b0, 1'b1, 1'b1, 4'd12, 1'b0);
    repeat (301) tick();
    check_out(0, "sat300", 1, 3, 255, 45, 1);

    // Asynchronous reset in the middle of CHECK
    #2;
    reset = 1'b1;
    #1;
    check_out(0, "async rst", 0, 0, 0, 0, 0);
    check_out(1, "async rst", 0, 0, 0, 0, 0);
`ifdef CHECKER_ERR_CAPTURE_EN
    check("async rst err_obs", int'(bus0.err_obs), 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    check_out(0, "post rst idle", 0, 0, 0, 1, 1);
    tick();
    check_out(0, "post rst chk", 1, 3, 1, 2, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_count_checker.md
MOD_COUNT_CHECKER -- requirements
Module: mod_count_checker

Interface
REQ-001 Parameter MOD_MAX, default 12: terminal value of the monitored modulo counter, which counts 0..MOD_MAX.
REQ-002 Parameter W, default 4: width of the observed count; the SHALL-hold rule is MOD_MAX < 2**W.
REQ-003 Parameter STOP_ON_ERR, default 0: 1 = the first mismatch freezes checking.
REQ-004 clk  input  1  clock; all state updates on posedge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 clear  input  1  synchronous clear of error/statistic state.
REQ-007 chk_en  input  1  arms comparison.
REQ-008 en_obs  input  1  enable as driven into the monitored counter.
REQ-009 count_obs  input  W  monitored counter value.
REQ-010 carry_obs  input  1  monitored counter carry output.
REQ-011 err_flag  output  1  sticky: any mismatch since reset/clear.
REQ-012 err_code  output  2  first error code: 00 none, 01 count, 10 carry, 11 both.
REQ-013 err_cnt  output  8  mismatching cycles, saturates at 255.
REQ-014 wrap_cnt  output  8  observed wrap events, modulo 256.
REQ-015 state_o  output  2  FSM state: 00 IDLE, 01 CHECK, 10 HALT.

Function
REQ-016 The block SHALL hold the model registers exp_cnt[W-1:0] and exp_carry, compared against the pre-edge values of count_obs/carry_obs sampled at each posedge.
REQ-017 Define next(v) = 0 if v >= MOD_MAX, else v+1.
REQ-018 Model update with en_obs=1: exp_cnt <= next(base); exp_carry <= (base >= MOD_MAX).
REQ-019 Model update with en_obs=0: exp_cnt <= base; exp_carry <= exp_carry.
REQ-020 base = count_obs in IDLE or on a mismatch cycle (resynchronisation, no error cascade); base = exp_cnt otherwise.
REQ-021 IDLE: no comparison; the model shadows the observed counter; chk_en=1 -> CHECK on the next edge.
REQ-022 CHECK: mismatch = (count_obs != exp_cnt) or (carry_obs != exp_carry); chk_en=0 -> IDLE.
REQ-023 Mismatch effects: err_flag <= 1; err_cnt increments, saturating at 255; err_code is loaded only when err_flag was 0.
REQ-024 A mismatch with STOP_ON_ERR=1 SHALL move the FSM to HALT, where the model and all counters freeze until clear.
REQ-025 A count_obs value above MOD_MAX in CHECK SHALL be a count mismatch, and resync per REQ-020 SHALL then give exp_cnt = 0 when en_obs=1.
REQ-026 wrap_cnt SHALL increment in IDLE or CHECK whenever en_obs=1 and count_obs == MOD_MAX, wrapping 255 -> 0.
REQ-027 clear=1 SHALL zero err_flag, err_code, err_cnt and wrap_cnt, and move the FSM to IDLE; it takes precedence over any same-cycle mismatch or wrap.
REQ-028 All outputs SHALL be registered: zero combinational paths from inputs to outputs.

Reset
REQ-029 reset SHALL asynchronously force IDLE, exp_cnt=0, exp_carry=0, and every output to 0.
REQ-030 reset asserted mid-CHECK SHALL discard the in-flight comparison; the first comparison after release SHALL need chk_en sampled high in IDLE.

Configuration
REQ-031 With the macro CHECKER_ERR_CAPTURE_EN defined, the block SHALL add outputs err_exp[W-1:0] and err_obs[W-1:0], which capture exp_cnt and count_obs of the first mismatch and are cleared by reset/clear.
REQ-032 With CHECKER_ERR_CAPTURE_EN undefined, those ports and registers SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-033 A shared package SHALL hold the state encoding (IDLE/CHECK/HALT), the err_code constants and the 8-bit statistic width.
REQ-034 One sub-module, sat_counter8 (8-bit counter with an increment input, a saturate/wrap mode input and a synchronous clear), SHALL implement both err_cnt and wrap_cnt.

Verification
REQ-035 Reset, then chk_en=1 and en_obs=1 for 30 cycles, fed by a correct 0..12 counter -> err_flag=0, wrap_cnt=2.
REQ-036 Correct counter, with count_obs forced to 5 while the model expects 7 -> err_code=01, err_cnt=1, no further errors after resync.
REQ-037 carry_obs forced to 1 at count 3 -> err_code=10; a later both-field error -> err_code stays 10, err_cnt=2.
REQ-038 STOP_ON_ERR=1, inject one mismatch -> state_o=10 and counters frozen; assert clear -> state_o=00, all counters 0.
REQ-039 count_obs=15 with en_obs=1 in CHECK -> count error, exp_cnt=0 next cycle; with CHECKER_ERR_CAPTURE_EN, err_obs=15.
REQ-040 err_cnt driven by 300 mismatching cycles -> holds 255; reset asserted mid-run -> all outputs 0 asynchronously.
